// File: rtl/arb_mux_n_to_1.sv
// arb_mux_n_to_1: registered N:1 mux with fixed-select or round-robin arbitration
// and a single-entry output register with valid/ready handshake.
module arb_mux_n_to_1 #(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 4,
   parameter int SEL_W  = $clog2(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    mode,
   input  logic [SEL_W-1:0]        sel_i,
   input  logic [NUM_IN-1:0]       in_valid,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   output logic [NUM_IN-1:0]       in_ready,
   output logic                    out_valid,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_sel,
   input  logic                    out_ready
);
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;
   logic [SEL_W-1:0] r_out_sel;
   logic [SEL_W-1:0] r_rr_ptr;
   logic             w_load_en;
   logic             w_rr_vld;
   logic [SEL_W-1:0] w_rr_gnt;
   logic             w_gnt_vld;
   logic [SEL_W-1:0] w_gnt;
   logic             w_xfer;
   logic [WIDTH-1:0] w_gnt_data;
   assign w_load_en = !r_out_valid || out_ready;
   // Descending scan so the nearest channel after r_rr_ptr wins; NUM_IN is a power of two so index wrap is free.
   always_comb begin
      w_rr_vld = 1'b0;
      w_rr_gnt = '0;
      for (int k = NUM_IN; k >= 1; k--) begin
         if (in_valid[r_rr_ptr + SEL_W'(k)]) begin
            w_rr_vld = 1'b1;
            w_rr_gnt = r_rr_ptr + SEL_W'(k);
         end
      end
   end
   assign w_gnt      = mode ? w_rr_gnt : sel_i;
   assign w_gnt_vld  = mode ? w_rr_vld : in_valid[sel_i];
   assign w_xfer     = rst_n && w_load_en && w_gnt_vld;
   assign w_gnt_data = in_data[w_gnt*WIDTH +: WIDTH];
   for (genvar i = 0; i < NUM_IN; i++) begin : g_rdy
      assign in_ready[i] = w_xfer && (w_gnt == SEL_W'(i));
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sel   <= '0;
         r_rr_ptr    <= SEL_W'(NUM_IN - 1);
      end else begin
         if (w_load_en) r_out_valid <= w_xfer;
         if (w_xfer) begin
            r_out_data <= w_gnt_data;
            r_out_sel  <= w_gnt;
         end
         if (w_xfer && mode) r_rr_ptr <= w_gnt;
      end
   end
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_sel   = r_out_sel;
endmodule

// File: tb/tb_arb_mux_n_to_1.sv
// tb_arb_mux_n_to_1: directed vectors plus a per-cycle reference model for the 4x32 instance,
// and directed checks for a 16x8 instance.
module tb_arb_mux_n_to_1;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         mode = 1'b1;
   logic [1:0]   sel_i = 2'd0;
   logic [3:0]   in_valid = 4'h0;
   logic [127:0] in_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
   logic [3:0]   in_ready;
   logic         out_valid;
   logic [31:0]  out_data;
   logic [1:0]   out_sel;
   logic         out_ready = 1'b1;
   logic [3:0]   sel16 = 4'hF;
   logic [15:0]  in_valid16 = 16'h8000;
   logic [127:0] in_data16 = 'x;
   logic [15:0]  in_ready16;
   logic         out_valid16;
   logic [7:0]   out_data16;
   logic [3:0]   out_sel16;
   int           total = 0;
   int           bad = 0;
   logic         chk_en = 1'b0;
   always #5 clk = ~clk;
   arb_mux_n_to_1 dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .sel_i(sel_i), .in_valid(in_valid),
      .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
      .out_sel(out_sel), .out_ready(out_ready)
   );
   arb_mux_n_to_1 #(.WIDTH(8), .NUM_IN(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .mode(mode), .sel_i(sel16), .in_valid(in_valid16),
      .in_data(in_data16), .in_ready(in_ready16), .out_valid(out_valid16), .out_data(out_data16),
      .out_sel(out_sel16), .out_ready(out_ready)
   );
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
      end
   endtask
   // Reference model: the grant is found by plain modular search over the request vector.
   function automatic int pick(input logic md, input logic [1:0] s, input logic [3:0] v, input int ptr);
      if (!md) return v[s] ? int'(s) : -1;
      for (int k = 1; k <= 4; k++) if (v[(ptr + k) % 4]) return (ptr + k) % 4;
      return -1;
   endfunction
   logic        m_v;
   logic [31:0] m_d;
   logic [1:0]  m_s;
   int          m_p;
   int          m_g;
   logic [3:0]  exp_rdy;
   always_comb begin
      m_g = pick(mode, sel_i, in_valid, m_p);
      exp_rdy = (rst_n && (!m_v || out_ready) && m_g >= 0) ? 4'(1 << m_g) : 4'h0;
   end
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_v <= 1'b0;
         m_d <= '0;
         m_s <= '0;
         m_p <= 3;
      end else if (!m_v || out_ready) begin
         m_v <= (m_g >= 0);
         if (m_g >= 0) begin
            m_d <= in_data[m_g*32 +: 32];
            m_s <= 2'(m_g);
            if (mode) m_p <= m_g;
         end
      end
   end
   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_in_ready", in_ready, exp_rdy);
         chk("model_out_valid", out_valid, m_v);
         chk("model_out_data", out_data, m_d);
         chk("model_out_sel", out_sel, m_s);
      end
   end
   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
   initial begin
      int es1[5] = '{0, 1, 2, 3, 0};
      int es4[4] = '{3, 0, 3, 0};
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_sel", out_sel, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid16", out_valid16, 0);
      chk_en = 1'b1;
      rst_n = 1'b1;
      mode = 1'b1;
      in_valid = 4'hF;
      @(posedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("rr_seq_sel", out_sel, es1[i]);
         chk("rr_seq_data", out_data, 32'hA0 + es1[i]);
         chk("rr_seq_valid", out_valid, 1);
      end
      @(posedge clk); #1;
      mode = 1'b0; sel_i = 2'd2; in_valid = 4'b1011;
      @(negedge clk);
      chk("fix_no_req_ready", in_ready, 4'h0);
      @(negedge clk);
      chk("fix_no_req_valid", out_valid, 0);
      @(posedge clk); #1;
      in_valid = 4'hF;
      @(negedge clk);
      chk("fix_req_ready", in_ready, 4'b0100);
      @(negedge clk);
      chk("fix_sel", out_sel, 2);
      chk("fix_data", out_data, 32'hA2);
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_data[64 +: 32] = 32'hB2;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_valid", out_valid, 1);
         chk("stall_ready", in_ready, 4'h0);
         chk("stall_data", out_data, 32'hA2);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("unstall_ready", in_ready, 4'b0100);
      @(negedge clk);
      chk("unstall_data", out_data, 32'hB2);
      @(posedge clk); #1;
      in_data[64 +: 32] = 32'hA2;
      mode = 1'b1; in_valid = 4'b0111;
      @(negedge clk);
      chk("rr_ptr_held_ready", in_ready, 4'b0100);
      @(posedge clk); #1;
      in_valid = 4'b1001;
      @(negedge clk);
      chk("rr_alt_first_ready", in_ready, 4'b1000);
      chk("rr_alt_prev_sel", out_sel, 2);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rr_alt_sel", out_sel, es4[i]);
      end
      @(posedge clk); #1;
      in_valid = 4'hF;
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", out_valid, 0);
      chk("async_rst_data", out_data, 0);
      chk("async_rst_sel", out_sel, 0);
      chk("async_rst_ready", in_ready, 0);
      chk("async_rst_valid16", out_valid16, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", in_ready, 4'b0001);
      @(negedge clk);
      chk("post_rst_sel", out_sel, 0);
      chk("post_rst_data", out_data, 32'hA0);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         in_data16[120 +: 8] = 8'h60 + 8'(k);
         @(negedge clk);
         chk("n16_ready", in_ready16, 16'h8000);
         chk("n16_sel", out_sel16, 4'hF);
         chk("n16_valid", out_valid16, 1);
         if (k > 0) chk("n16_data", out_data16, 8'h60 + 8'(k - 1));
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
